// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg
// Definitions shared by both ends of the serial parity link (generator and
// checker). It holds the frame FSM state encoding, the line-level constants
// for the start and stop bits, and the parity-mode encoding.
// Contents:
//   state_t      frame FSM states: IDLE, DATA, PARITY, STOP, WAIT
//   START_BIT    line level of a start bit (0)
//   STOP_BIT     line level of a stop bit / idle line (1)
//   PAR_EVEN/ODD parity-mode encoding
//   parity_mode  maps an integer PARITY_ODD parameter onto the encoding
package serial_parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    WAIT   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic parity_mode(input int odd);
    return (odd != 0) ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/par_shift_acc.sv
// par_shift_acc
// Deserialising shift register with a running XOR accumulator over every bit
// shifted in. Bits enter at the MSB end and move toward bit 0. After DATA_W
// shifts, the first bit received therefore sits in bit 0, so an LSB-first
// stream assembles in natural order.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (clears register and accumulator)
//   clr       synchronous clear at the start of a frame (takes priority)
//   shift_en  shift bit_in in and fold it into the accumulator
//   bit_in    serial input bit
//   shreg     DATA_W-bit assembled word
//   acc       XOR of every bit shifted in since the last clear
module par_shift_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] shreg,
  output logic              acc
);

  logic [DATA_W-1:0] shreg_next;

  // A shift followed by an MSB overwrite works for every width, including
  // DATA_W = 1, where a {bit_in, shreg[DATA_W-1:1]} slice would be reversed.
  always_comb begin
    shreg_next           = shreg >> 1;
    shreg_next[DATA_W-1] = bit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      acc   <= 1'b0;
    end else if (clr) begin
      shreg <= '0;
      acc   <= 1'b0;
    end else if (shift_en) begin
      shreg <= shreg_next;
      acc   <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Receive side of the serial parity link. It deserialises frames of the form
// start(0), DATA_W data bits LSB-first, parity, stop(1). It recomputes parity
// over the data bits only, then presents the word with a one-cycle valid
// pulse and parity/framing error flags.
// Parameters:
//   DATA_W      data bits per frame (1..32)
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
// Ports:
//   clk        rising-edge clock; x is sampled on every edge
//   rst        asynchronous active-high reset
//   x          serial line, idles high
//   data       last received word (held until the next commit)
//   valid      one-cycle pulse on every completed frame, errored or not
//   par_err    parity mismatch on the last frame
//   frame_err  stop bit was 0 on the last frame
//   err_cnt    [7:0] saturating count of errored frames (only with
//              SERIAL_PARITY_CHECKER_ERRCNT_EN defined)
// Output handshake: valid is a pure strobe with no ready. A consumer must
// take data/par_err/frame_err in the cycle valid is high. Those outputs
// hold their values afterwards but are not re-announced.
// The current FSM state is kept in the enum-typed signal `state` so it can
// be probed directly.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              par_err,
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
  output logic              frame_err,
  output logic [7:0]        err_cnt
`else
  output logic              frame_err
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               mism_q, mism_next;
  logic               clr, shift_en, commit;
  logic [DATA_W-1:0]  shreg;
  logic               acc;

  par_shift_acc #(.DATA_W(DATA_W)) u_shift_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (x),
    .shreg    (shreg),
    .acc      (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mism_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      mism_q <= mism_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mism_next  = mism_q;
    clr        = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (x == START_BIT) begin
          state_next = DATA;
          cnt_next   = '0;
          clr        = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          state_next = PARITY;
          cnt_next   = '0;
        end
      end
      PARITY: begin
        // acc already holds every data bit; the parity bit itself stays out.
        mism_next  = acc ^ x ^ parity_mode(PARITY_ODD);
        state_next = STOP;
      end
      STOP: begin
        commit     = 1'b1;
        // A low stop bit means the line may still be low. WAIT stops that
        // level from being mistaken for the next start bit.
        state_next = (x == STOP_BIT) ? IDLE : WAIT;
      end
      WAIT: begin
        if (x == STOP_BIT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= commit;
      if (commit) begin
        data      <= shreg;
        par_err   <= mism_q;
        frame_err <= (x != STOP_BIT);
      end
    end
  end

`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
  // A frame with both errors still counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (commit && (mism_q || (x != STOP_BIT)) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker
// Drives one serial stream into two checkers: one set for even parity and
// one for odd parity. Each frame's expected outcome for both instances is
// queued when the frame is driven. The monitor pops that entry when valid
// pulses and compares data, flags and the exact commit cycle.
module tb_serial_parity_checker;

  localparam int DATA_W = 8;
  localparam int EXP_W  = DATA_W + 3;
  localparam int LAT    = DATA_W + 2;

  logic              clk;
  logic              rst;
  logic              x;
  logic [DATA_W-1:0] data_e, data_o;
  logic              valid_e, valid_o;
  logic              pe_e, pe_o;
  logic              fe_e, fe_o;
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
  logic [7:0]        err_cnt_e, err_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int cyc      = 0;

  // Packed as {frame_err, par_err(odd dut), par_err(even dut), data}.
  logic [EXP_W-1:0] exp_q[$];
  int               exp_t_q[$];
  logic [EXP_W-1:0] mon_exp;
  int               mon_t;

  serial_parity_checker #(.DATA_W(DATA_W), .PARITY_ODD(0)) u_even (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .data      (data_e),
    .valid     (valid_e),
    .par_err   (pe_e),
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
    .frame_err (fe_e),
    .err_cnt   (err_cnt_e)
`else
    .frame_err (fe_e)
`endif
  );

  serial_parity_checker #(.DATA_W(DATA_W), .PARITY_ODD(1)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .data      (data_o),
    .valid     (valid_o),
    .par_err   (pe_o),
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
    .frame_err (fe_o),
    .err_cnt   (err_cnt_o)
`else
    .frame_err (fe_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && (valid_e || valid_o)) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_valid: valid_e=%0b valid_o=%0b cycle=%0d, required no pulse",
                 valid_e, valid_o, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_t   = exp_t_q.pop_front();
        if ({valid_e, valid_o} !== 2'b11) begin
          n_errors++;
          $display("FAIL valid_pair: got %b, required 11", {valid_e, valid_o});
        end
        n_checks++;
        if (cyc !== mon_t) begin
          n_errors++;
          $display("FAIL valid_latency: cycle %0d, required %0d", cyc, mon_t);
        end
        n_checks++;
        if (data_e !== mon_exp[DATA_W-1:0] || data_o !== mon_exp[DATA_W-1:0]) begin
          n_errors++;
          $display("FAIL data: even=%h odd=%h, required %h", data_e, data_o, mon_exp[DATA_W-1:0]);
        end
        n_checks++;
        if (pe_e !== mon_exp[DATA_W] || pe_o !== mon_exp[DATA_W+1]) begin
          n_errors++;
          $display("FAIL par_err: even=%b odd=%b, required even=%b odd=%b",
                   pe_e, pe_o, mon_exp[DATA_W], mon_exp[DATA_W+1]);
        end
        n_checks++;
        if (fe_e !== mon_exp[DATA_W+2] || fe_o !== mon_exp[DATA_W+2]) begin
          n_errors++;
          $display("FAIL frame_err: even=%b odd=%b, required %b", fe_e, fe_o, mon_exp[DATA_W+2]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    x = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
    logic pe_even;
    logic pe_odd;
    pe_even = (^d) ^ p;
    pe_odd  = ~pe_even;
    drive_bit(1'b0);
    exp_q.push_back({~s, pe_odd, pe_even, d});
    exp_t_q.push_back(cyc + 1 + LAT);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    x   = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({valid_e, pe_e, fe_e, valid_o, pe_o, fe_o} !== 6'b0 || data_e !== '0 || data_o !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: v/pe/fe=%b data_e=%h data_o=%h, required all 0",
               {valid_e, pe_e, fe_e, valid_o, pe_o, fe_o}, data_e, data_o);
    end
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
    n_checks++;
    if (err_cnt_e !== 8'd0 || err_cnt_o !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_err_cnt: even=%0d odd=%0d, required 0", err_cnt_e, err_cnt_o);
    end
`endif
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(3);
    n_checks++;
    if (valid_e !== 1'b0 || data_e !== 8'hA5 || pe_e !== 1'b0 || pe_o !== 1'b1) begin
      n_errors++;
      $display("FAIL good_frame_hold: valid=%b data=%h pe_e=%b pe_o=%b, required 0 a5 0 1",
               valid_e, data_e, pe_e, pe_o);
    end
  endtask

  task automatic test_parity_err;
    send_frame(8'h01, 1'b0, 1'b1);
    idle(3);
    n_checks++;
    if (pe_e !== 1'b1 || pe_o !== 1'b0 || data_e !== 8'h01 || fe_e !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_err_hold: pe_e=%b pe_o=%b data=%h fe=%b, required 1 0 01 0",
               pe_e, pe_o, data_e, fe_e);
    end
  endtask

  task automatic test_frame_err;
    int v_before;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (5) drive_bit(1'b0);
    n_checks++;
    if (fe_e !== 1'b1 || fe_o !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_err_hold: even=%b odd=%b, required 1", fe_e, fe_o);
    end
    v_before = n_valid;
    drive_bit(1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(3);
    n_checks++;
    if (n_valid !== v_before + 1 || fe_e !== 1'b0 || data_e !== 8'hC3) begin
      n_errors++;
      $display("FAIL frame_err_recover: pulses=%0d fe=%b data=%h, required 1 0 c3",
               n_valid - v_before, fe_e, data_e);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    idle(3);
    n_checks++;
    if (data_e !== 8'h80 || pe_e !== 1'b0 || fe_e !== 1'b0) begin
      n_errors++;
      $display("FAIL back_to_back_final: data=%h pe=%b fe=%b, required 80 0 0", data_e, pe_e, fe_e);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v_before;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid_e, pe_e, fe_e, valid_o, pe_o, fe_o} !== 6'b0 || data_e !== '0 || data_o !== '0) begin
      n_errors++;
      $display("FAIL mid_frame_reset: v/pe/fe=%b data_e=%h data_o=%h, required all 0",
               {valid_e, pe_e, fe_e, valid_o, pe_o, fe_o}, data_e, data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    x   = 1'b1;
    idle(2);
    v_before = n_valid;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(3);
    n_checks++;
    if (n_valid !== v_before + 1 || data_e !== 8'h5A) begin
      n_errors++;
      $display("FAIL after_reset_frame: pulses=%0d data=%h, required 1 5a", n_valid - v_before, data_e);
    end
  endtask

`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
  task automatic test_err_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    repeat (3) send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (err_cnt_e !== 8'd4 || err_cnt_o !== 8'd1) begin
      n_errors++;
      $display("FAIL err_cnt_four: even=%0d odd=%0d, required 4 1", err_cnt_e, err_cnt_o);
    end
    repeat (300) send_frame(8'h00, 1'b1, 1'b0);
    idle(3);
    n_checks++;
    if (err_cnt_e !== 8'd255 || err_cnt_o !== 8'd255) begin
      n_errors++;
      $display("FAIL err_cnt_saturate: even=%0d odd=%0d, required 255", err_cnt_e, err_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SERIAL_PARITY_CHECKER_ERRCNT_EN
    test_err_cnt();
`endif
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
